sub64_iter: RTL and testbench

SUB64_ITER -- requirements
Module: sub64_iter

---
 rtl/sub64_iter.sv | 122 ++++++++++++
 tb/tb_sub64_iter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sub64_iter.sv
// sub64_iter: iterative 64-bit subtractor, diff = a - b - bin, CHUNK bits per cycle.
// Latency: 64/CHUNK+1 cycles from the accept edge to out_valid (5 for CHUNK=16).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
//
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, bin operands;
//        out_valid/out_ready with diff, bout results; busy high in CALC and DONE.
// Optional feature: define SUB64_SAT_EN to clamp diff to zero when the final borrow is 1.
module sub64_iter #(
  parameter int CHUNK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] diff,
  output logic        bout,
  output logic        busy
);

  localparam int NCH = 64 / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [63:0]     a_sh, b_sh;   // operands, shifted right so the live chunk sits at bit 0
  logic [63:0]     work;         // result under construction, filled from the top
  logic [63:0]     work_nxt;
  logic            borrow;
  logic [IW-1:0]   idx;
  logic [CHUNK:0]  sum;
  logic            accept, release_res, last_chunk;

  assign accept      = in_valid & in_ready;
  assign release_res = out_valid & out_ready;
  assign last_chunk  = (idx == IW'(NCH - 1));

  // a_k + ~b_k + ~borrow: the carry out is the inverted chunk borrow
  assign sum = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, ~b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, ~borrow};

  // New slice enters at the top; after the last chunk slice 0 has reached bit 0
  generate
    if (CHUNK == 64) begin : g_full
      assign work_nxt = sum[63:0];
    end else begin : g_shift
      assign work_nxt = {sum[CHUNK-1:0], work[63:CHUNK]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept) state_nxt = CALC;
      end
      CALC: if (last_chunk) state_nxt = DONE;
      DONE: if (release_res) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      work      <= '0;
      borrow    <= 1'b0;
      idx       <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            idx    <= '0;
          end
        end
        CALC: begin
          a_sh   <= a_sh >> CHUNK;
          b_sh   <= b_sh >> CHUNK;
          work   <= work_nxt;
          borrow <= ~sum[CHUNK];
          idx    <= idx + IW'(1);
        end
        DONE: begin
          // First DONE cycle publishes the result; diff only ever shows complete values
          if (!out_valid) begin
            out_valid <= 1'b1;
            bout      <= borrow;
`ifdef SUB64_SAT_EN
            diff      <= borrow ? 64'h0 : work;
`else
            diff      <= work;
`endif
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub64_iter.sv
module tb_sub64_iter;

  typedef struct {
    logic [63:0] d;
    logic        b;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, bin, out_ready;
  logic [63:0] a, b;
  logic        in_ready, out_valid, bout, busy;
  logic [63:0] diff;

  logic        rst1, in_valid1, bin1, out_ready1;
  logic [63:0] a1, b1;
  logic        in_ready1, out_valid1, bout1, busy1;
  logic [63:0] diff1;

  int          checks = 0;
  int          failures = 0;
  res_t        sb[$];
  logic [63:0] last_diff = '0;

  always #5 clk = ~clk;

  sub64_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .busy(busy)
  );

  sub64_iter #(.CHUNK(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .bout(bout1), .busy(busy1)
  );

  function automatic res_t model(input logic [63:0] xa, input logic [63:0] xb, input logic xbin);
    logic [64:0] f;
    res_t r;
    f   = {1'b0, xa} - {1'b0, xb} - {64'b0, xbin};
    r.b = f[64];
    r.d = f[63:0];
`ifdef SUB64_SAT_EN
    if (r.b) r.d = 64'h0;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers operands until accepted; returns just after the accept edge
  task automatic issue(input logic [63:0] xa, input logic [63:0] xb, input logic xbin);
    int n = 0;
    a = xa; b = xb; bin = xbin; in_valid = 1'b1;
    while (!in_ready && n < 50) begin tick(); n++; end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
    end
    sb.push_back(model(xa, xb, xbin));
    tick();
    in_valid = 1'b0;
  endtask

  // Waits for the result, checks latency/value/hold, then releases it
  task automatic collect(input string nm, input int exp_lat);
    int   lat = 0;
    res_t e;
    bit   hold_bad = 0;
    while (!out_valid && lat < 200) begin
      if (diff !== last_diff) hold_bad = 1;
      tick();
      lat++;
    end
    checks++;
    if (hold_bad) begin
      failures++;
      $display("FAIL %s_hold: diff changed before completion, required %h", nm, last_diff);
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d required %0d", nm, lat, exp_lat);
    end
    e = sb.pop_front();
    checks++;
    if (diff !== e.d || bout !== e.b) begin
      failures++;
      $display("FAIL %s_result: diff=%h bout=%b required diff=%h bout=%b", nm, diff, bout, e.d, e.b);
    end
    last_diff = e.d;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_release: in_ready=%b out_valid=%b required 1 0", nm, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst1 = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; bin1 = 1'b0;
    tick(); tick();
    rst = 1'b0; rst1 = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy, bout} !== 4'b1000 || diff !== 64'h0) begin
      failures++;
      $display("FAIL reset: in_ready,out_valid,busy,bout=%b diff=%h required 1000 0", {in_ready, out_valid, busy, bout}, diff);
    end
  endtask

  task automatic test_basic();
    issue(64'h10, 64'h3, 1'b0);                 collect("basic_10m3", 5);
    issue(64'h0, 64'h0, 1'b1);                  collect("zero_bin", 5);
    issue(64'h1_0000_0000, 64'h1, 1'b0);        collect("ripple", 5);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1); collect("max_bin", 5);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      issue({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      collect("random", 5);
    end
  endtask

  task automatic test_stall();
    int          n = 0;
    logic [63:0] hd;
    logic        hb;
    bit          bad = 0;
    res_t        e;
    issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    while (!out_valid && n < 200) begin tick(); n++; end
    hd = diff; hb = bout;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = ~bin;
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || diff !== hd || bout !== hb) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL stall_hold: out_valid=%b in_ready=%b diff=%h required 1 0 %h", out_valid, in_ready, diff, hd);
    end
    e = sb.pop_front();
    checks++;
    if (hd !== e.d || hb !== e.b) begin
      failures++;
      $display("FAIL stall_result: diff=%h bout=%b required %h %b", hd, hb, e.d, e.b);
    end
    last_diff = e.d;
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    issue(64'hDEAD, 64'hBEEF, 1'b0);
    tick();          // now in the 2nd CALC cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    last_diff = '0;
    checks++;
    if ({in_ready, out_valid, busy, bout} !== 4'b1000 || diff !== 64'h0) begin
      failures++;
      $display("FAIL midreset_state: in_ready,out_valid,busy,bout=%b diff=%h required 1000 0", {in_ready, out_valid, busy, bout}, diff);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midreset_no_result: out_valid seen=1 required 0");
    end
    issue(64'h5, 64'h3, 1'b0);
    collect("after_reset", 5);
  endtask

  task automatic test_chunk1();
    int lat = 0;
    a1 = 64'h8000_0000_0000_0000; b1 = 64'h1; bin1 = 1'b0; in_valid1 = 1'b1;
    checks++;
    if (in_ready1 !== 1'b1) begin
      failures++;
      $display("FAIL chunk1_ready: in_ready=%b required 1", in_ready1);
    end
    tick();
    in_valid1 = 1'b0;
    while (!out_valid1 && lat < 200) begin tick(); lat++; end
    checks++;
    if (lat !== 65) begin
      failures++;
      $display("FAIL chunk1_latency: got %0d required 65", lat);
    end
    checks++;
    if (diff1 !== 64'h7FFF_FFFF_FFFF_FFFF || bout1 !== 1'b0) begin
      failures++;
      $display("FAIL chunk1_result: diff=%h bout=%b required 7fffffffffffffff 0", diff1, bout1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_chunk1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
